freq_meter_gated: RTL and testbench
===================================

# freq_meter_gated

Parametrised gated-window frequency meter with a scanned 7-segment display driver. It counts rising edges of an asynchronous input in a BCD cascade over a selectable 1 s or 0.1 s gate. It latches the result with a valid strobe and an overflow flag, and multiplexes the latched digits onto an active-low common-anode display. It supersedes the fixed 8-digit, fixed 1 s meter and sits between the external signal pin and the board display/LEDs.

## Interface
- CLK_HZ, 50000000: clk frequency; gate lengths are CLK_HZ cycles (1 s) and CLK_HZ/10 cycles (0.1 s). Must be a multiple of 10.
- DIGITS, 8: number of BCD digits and display positions; legal range 2..10.
- SCAN_DIV, 65536: clk cycles each display digit is held; must be ≥1.
- SYNC_STAGES, 2: synchroniser flops on input_clk; must be ≥2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- input_clk  in  1  measured signal, asynchronous to clk.
- gate_sel  in  1  0 = 1 s gate, 1 = 0.1 s gate; sampled at window start only.
- result_bcd  out  4*DIGITS  latched frequency in Hz, BCD, digit 0 in [3:0].
- result_valid  out  1  one-cycle pulse when result_bcd/overflow update.
- overflow  out  1  latched window exceeded counter range.
- led  out  1  toggles at each window end.
- segments  out  8  active-low {a,b,c,d,e,f,g,dp}; dp is bit 0.
- segments_bit  out  DIGITS  active-low digit enable; bit k drives digit k.

## Operation
- input_clk passes through a SYNC_STAGES flop chain, then a one-flop rising-edge detector; one edge produces one count.
- Count cascade: DIGITS BCD digits, each 0..9, with ripple carry in a single cycle.
  - Active width is DIGITS digits in 1 s mode and DIGITS-1 digits in 0.1 s mode.
  - Saturates at all-9s of the active width; a further edge sets an internal sat flag and leaves the count unchanged.
- Gate timer: 0..G-1, where G = CLK_HZ in 1 s mode and CLK_HZ/10 in 0.1 s mode. gate_sel is registered into a mode flop when the timer is 0.
- At timer == G-1 (window end):
  - result_bcd ← count, in 1 s mode.
  - result_bcd ← {count[4*(DIGITS-1)-1:0], 4'd0}, in 0.1 s mode (value ×10 = Hz).
  - overflow ← sat. result_valid pulses. led toggles.
  - Count, sat and timer clear; the next window starts on the next cycle.
  - An edge detected on the window-end cycle is counted into the closing window.
- Display scan:
  - Digit index k cycles 0→DIGITS-1→0; each digit is held SCAN_DIV cycles.
  - segments_bit has only bit k low. segments shows the glyph of result_bcd digit k.
  - Glyphs, active-low, dp=1 (off): 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001.
  - Codes 10..15 do not occur; they map to 11111111.
  - dp is lit (bit0=0) on digit 0 while overflow=1.
- segments and segments_bit are registered and change together.

## Timing
- Reset values:
  - result_bcd=0, result_valid=0, overflow=0, led=0.
  - segments=8'hFF, segments_bit all ones.
  - Timer, count, sat, scan counter and sync chain = 0; mode=0.
- The first window starts on the first cycle after reset deasserts (timer=0). result_valid first pulses G cycles later, in cycle index G-1.
- Edge-to-count latency is SYNC_STAGES+1 cycles. Edges within that distance of a boundary fall into the next window.
- Maximum measurable frequency is CLK_HZ/2; input pulses shorter than one clk may be missed.
- The display updates the cycle after result_bcd changes. The scan runs continuously and is not reset by window ends.
- The first digit (k=0) is enabled SCAN_DIV cycles after reset; before that, all digits are off.
- A reset mid-window discards the partial count, clears results, and restarts the window and scan.
- A gate_sel change mid-window takes effect only at the next window start.

## Configuration
- FREQ_METER_LZB_EN, when defined, enables leading-zero blanking:
  - Digit k>0 shows 11111111 when it and all higher digits of result_bcd are 0.
  - Digit 0 is always shown.
  - Overflow dp is unaffected.
- Without FREQ_METER_LZB_EN, every digit shows its glyph, including leading zeros.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_DIV=4, DIGITS=4 unless stated.

- **1 s gate:** input_clk period 10 clk, gate_sel=0 → first result_valid at cycle 999; result_bcd=16'h0100, overflow=0; led=1.
- **0.1 s gate:** same input, gate_sel=1 → valid every 100 cycles; result_bcd=16'h0100 (10 edges ×10); digit 0 glyph 00000011.
- **Overflow:** DIGITS=3, input period 2 clk, gate_sel=0 → 500 edges counted, so result_bcd=12'h500, overflow=0.
  - Then DIGITS=2, same input → result_bcd=8'h99, overflow=1, dp low on digit 0.
- **Mid-window mode change:** gate_sel 0→1 at cycle 300 → next valid at cycle 999; the following valid at cycle 1099.
- **Reset mid-window:** reset at cycle 500 for 3 cycles → outputs at reset values; next valid 1000 cycles after release; count excludes pre-reset edges.
- **Display scan:**
  - segments_bit steps 1110→1101→1011→0111, each held 4 cycles.
  - With FREQ_METER_LZB_EN and result 16'h0042, digits 3 and 2 show 11111111.
  - Without the macro, digits 3 and 2 show 00000011.

Source files
------------

// File: rtl/freq_meter_gated.sv
// Gated-window frequency meter: BCD edge counter over a 1 s / 0.1 s gate, latched result, scanned 7-seg driver.
// Latency: edges counted SYNC_STAGES+1 clk after arrival; result/valid at window end, display one clk later.
// No backpressure: result_valid is a one-cycle strobe. Leading-zero blanking is enabled by defining FREQ_METER_LZB_EN.
module freq_meter_gated #(
   parameter int CLK_HZ      = 50000000,
   parameter int DIGITS      = 8,
   parameter int SCAN_DIV    = 65536,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                input_clk,
   input  logic                gate_sel,
   output logic [4*DIGITS-1:0] result_bcd,
   output logic                result_valid,
   output logic                overflow,
   output logic                led,
   output logic [7:0]          segments,
   output logic [DIGITS-1:0]   segments_bit
);

   localparam int G_LONG  = CLK_HZ;
   localparam int G_SHORT = CLK_HZ / 10;
   localparam int TW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int KW      = $clog2(DIGITS);
   localparam int BW      = 4 * DIGITS;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rise_prev_q;
   logic                   rise;
   logic                   mode_q;
   logic [TW-1:0]          timer_q;
   logic                   win_end;
   logic [BW-1:0]          cnt_q, cnt_d;
   logic                   sat_q, sat_d;
   logic                   all9, carry;
   logic [BW-1:0]          result_q;
   logic                   valid_q, overflow_q, led_q;
   logic [DW-1:0]          div_q, div_d;
   logic [KW-1:0]          sel_q, sel_d;
   logic                   en_q, en_d;
   logic [7:0]             seg_q, seg_d, seg_g;
   logic [3:0]             shown;
   logic [DIGITS-1:0]      dig_q, dig_d;
`ifdef FREQ_METER_LZB_EN
   logic                   upper_nz;
`endif

   function automatic logic [7:0] seg_glyph(input logic [3:0] d);
      case (d)
         4'd0:    seg_glyph = 8'b0000_0011;
         4'd1:    seg_glyph = 8'b1001_1111;
         4'd2:    seg_glyph = 8'b0010_0101;
         4'd3:    seg_glyph = 8'b0000_1101;
         4'd4:    seg_glyph = 8'b1001_1001;
         4'd5:    seg_glyph = 8'b0100_1001;
         4'd6:    seg_glyph = 8'b0100_0001;
         4'd7:    seg_glyph = 8'b0001_1111;
         4'd8:    seg_glyph = 8'b0000_0001;
         4'd9:    seg_glyph = 8'b0000_1001;
         default: seg_glyph = 8'hFF;
      endcase
   endfunction

   assign rise    = sync_q[SYNC_STAGES-1] & ~rise_prev_q;
   assign win_end = (timer_q == (mode_q ? TW'(G_SHORT - 1) : TW'(G_LONG - 1)));

   // BCD ripple increment over the active width; saturate at all-9s instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      all9  = 1'b1;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((i < DIGITS - 1 || !mode_q) && cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
      end
      if (rise) begin
         if (all9) begin
            sat_d = 1'b1;
         end else begin
            for (int i = 0; i < DIGITS; i++) begin
               if (carry) begin
                  if (cnt_q[4*i +: 4] == 4'd9) begin
                     cnt_d[4*i +: 4] = 4'd0;
                  end else begin
                     cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                     carry = 1'b0;
                  end
               end
            end
         end
      end
   end

   // Synchroniser, gate timer, window-end latch of result (edge on the last cycle still counts)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         rise_prev_q <= 1'b0;
         mode_q      <= 1'b0;
         timer_q     <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         led_q       <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], input_clk};
         rise_prev_q <= sync_q[SYNC_STAGES-1];
         if (timer_q == '0) mode_q <= gate_sel;
         valid_q <= win_end;
         if (win_end) begin
            timer_q    <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            result_q   <= mode_q ? {cnt_d[BW-5:0], 4'd0} : cnt_d;
            overflow_q <= sat_d;
            led_q      <= ~led_q;
         end else begin
            timer_q <= timer_q + TW'(1);
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
         end
      end
   end

   // Scan sequencing and glyph selection; the shown digit refreshes every cycle
   always_comb begin
      div_d = div_q + DW'(1);
      sel_d = sel_q;
      en_d  = en_q;
      if (div_q == DW'(SCAN_DIV - 1)) begin
         div_d = '0;
         en_d  = 1'b1;
         if (!en_q || sel_q == KW'(DIGITS - 1)) sel_d = '0;
         else                                   sel_d = sel_q + KW'(1);
      end
      shown = result_q[4*int'(sel_d) +: 4];
      seg_g = seg_glyph(shown);
`ifdef FREQ_METER_LZB_EN
      upper_nz = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(sel_d) && result_q[4*i +: 4] != 4'd0) upper_nz = 1'b1;
      end
      if (sel_d != '0 && !upper_nz) seg_g = 8'hFF;
`endif
      if (sel_d == '0 && overflow_q) seg_g[0] = 1'b0;
      seg_d = 8'hFF;
      dig_d = '1;
      if (en_d) begin
         seg_d        = seg_g;
         dig_d[sel_d] = 1'b0;
      end
   end

   // Display registers: segments and digit enables change together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         sel_q <= '0;
         en_q  <= 1'b0;
         seg_q <= 8'hFF;
         dig_q <= '1;
      end else begin
         div_q <= div_d;
         sel_q <= sel_d;
         en_q  <= en_d;
         seg_q <= seg_d;
         dig_q <= dig_d;
      end
   end

   assign result_bcd   = result_q;
   assign result_valid = valid_q;
   assign overflow     = overflow_q;
   assign led          = led_q;
   assign segments     = seg_q;
   assign segments_bit = dig_q;

endmodule

// File: tb/tb_freq_meter_gated.sv
// Testbench for freq_meter_gated: two instances (4 and 2 digits) on shared stimulus,
// reference model counts input rises per window with plain arithmetic, scoreboard on result_valid.
module tb_freq_meter_gated;
   localparam int CLK_HZ = 1000;
   localparam int SCAN   = 4;
   localparam int SYNC   = 2;
   localparam int DA     = 4;
   localparam int DB     = 2;

   typedef struct {
      logic [39:0] bcd;
      bit          ovf;
      bit          led;
      int          stamp;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic input_clk = 1'b0;
   logic gate_sel = 1'b0;

   logic [4*DA-1:0] res_a;
   logic            val_a, ovf_a, led_a;
   logic [7:0]      seg_a;
   logic [DA-1:0]   sb_a;
   logic [4*DB-1:0] res_b;
   logic            val_b, ovf_b, led_b;
   logic [7:0]      seg_b;
   logic [DB-1:0]   sb_b;

   freq_meter_gated #(.CLK_HZ(CLK_HZ), .DIGITS(DA), .SCAN_DIV(SCAN), .SYNC_STAGES(SYNC)) u_dut_a (
      .clk(clk), .reset(reset), .input_clk(input_clk), .gate_sel(gate_sel),
      .result_bcd(res_a), .result_valid(val_a), .overflow(ovf_a), .led(led_a),
      .segments(seg_a), .segments_bit(sb_a));

   freq_meter_gated #(.CLK_HZ(CLK_HZ), .DIGITS(DB), .SCAN_DIV(SCAN), .SYNC_STAGES(SYNC)) u_dut_b (
      .clk(clk), .reset(reset), .input_clk(input_clk), .gate_sel(gate_sel),
      .result_bcd(res_b), .result_valid(val_b), .overflow(ovf_b), .led(led_b),
      .segments(seg_b), .segments_bit(sb_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          e = 0;
   int          last_e = -1;
   bit          prev_in = 1'b0;
   int          pend[$];
   int          win_end = -1;
   bit          mode = 1'b0;
   int          n = 0;
   logic [39:0] cur_a = '0, cur_b = '0, disp_a = '0, disp_b = '0, mb;
   bit          cur_oa = 1'b0, cur_ob = 1'b0, disp_oa = 1'b0, disp_ob = 1'b0, mo;
   bit          led_e = 1'b0;
   exp_t        qa[$], qb[$];
   exp_t        x;
   logic [7:0]  gly [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                             8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};

   function automatic logic [39:0] to_bcd(input int v);
      logic [39:0] r = '0;
      int          t = v;
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic void expect_window(input int digits, input bit md, input int cnt,
                                         output logic [39:0] bcd, output bit ovf);
      int w    = md ? digits - 1 : digits;
      int capv = 1;
      int v;
      for (int i = 0; i < w; i++) capv = capv * 10;
      capv = capv - 1;
      ovf  = (cnt > capv);
      v    = ovf ? capv : cnt;
      if (md) v = v * 10;
      bcd = to_bcd(v);
   endfunction

   function automatic logic [7:0] exp_seg(input logic [39:0] r, input int k, input bit ovf);
      logic [3:0] d = r[4*k +: 4];
      logic [7:0] g;
`ifdef FREQ_METER_LZB_EN
      bit nz = 1'b0;
`endif
      g = (d < 4'd10) ? gly[d] : 8'hFF;
`ifdef FREQ_METER_LZB_EN
      for (int i = k; i < 10; i++) if (r[4*i +: 4] != 4'd0) nz = 1'b1;
      if (k > 0 && !nz) g = 8'hFF;
`endif
      if (k == 0 && ovf) g[0] = 1'b0;
      return g;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, last_e);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s (edge %0d)", name, last_e);
   endtask

   task automatic chk_disp(input string tag, input int digits, input logic [7:0] seg,
                           input logic [9:0] sb, input logic [39:0] dres, input bit dovf);
      logic [9:0] esb  = '1;
      logic [7:0] eseg = 8'hFF;
      int         k;
      if (last_e >= SCAN - 1) begin
         k       = ((last_e - (SCAN - 1)) / SCAN) % digits;
         esb[k]  = 1'b0;
         eseg    = exp_seg(dres, k, dovf);
      end
      chk({tag, "_segments"}, seg, eseg);
      chk({tag, "_segments_bit"}, sb, esb);
   endtask

   // Reference model: a rise first sampled at edge i is counted at edge i+SYNC
   always @(posedge clk) begin
      if (reset) begin
         e = 0; last_e = -1; prev_in = 1'b0; pend.delete(); win_end = -1; n = 0; mode = 1'b0;
         cur_a = '0; cur_b = '0; cur_oa = 1'b0; cur_ob = 1'b0; led_e = 1'b0;
         qa.delete(); qb.delete();
      end else begin
         disp_a = cur_a; disp_b = cur_b; disp_oa = cur_oa; disp_ob = cur_ob;
         if (e > win_end) begin
            mode    = gate_sel;
            win_end = e + (gate_sel ? CLK_HZ / 10 : CLK_HZ) - 1;
         end
         if (input_clk && !prev_in) pend.push_back(e + SYNC);
         prev_in = input_clk;
         if (pend.size() > 0 && pend[0] == e) begin
            void'(pend.pop_front());
            n++;
         end
         if (e == win_end) begin
            led_e = !led_e;
            expect_window(DA, mode, n, mb, mo);
            cur_a = mb; cur_oa = mo;
            qa.push_back('{bcd: mb, ovf: mo, led: led_e, stamp: e});
            expect_window(DB, mode, n, mb, mo);
            cur_b = mb; cur_ob = mo;
            qb.push_back('{bcd: mb, ovf: mo, led: led_e, stamp: e});
            n = 0;
         end
         last_e = e;
         e++;
      end
   end

   // Monitor: sample between edges, pop expectations whenever a DUT reports a result
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_res_a", res_a, '0);   chk("rst_valid_a", val_a, 0); chk("rst_ovf_a", ovf_a, 0);
         chk("rst_led_a", led_a, 0);    chk("rst_seg_a", seg_a, 8'hFF); chk("rst_sb_a", sb_a, 4'hF);
         chk("rst_res_b", res_b, '0);   chk("rst_valid_b", val_b, 0); chk("rst_ovf_b", ovf_b, 0);
         chk("rst_led_b", led_b, 0);    chk("rst_seg_b", seg_b, 8'hFF); chk("rst_sb_b", sb_b, 2'h3);
      end else if (last_e >= 0) begin
         if (val_a) begin
            if (qa.size() == 0) fail_evt("valid_a_unexpected");
            else begin
               x = qa.pop_front();
               chk("win_res_a", res_a, x.bcd[4*DA-1:0]); chk("win_ovf_a", ovf_a, x.ovf);
               chk("win_led_a", led_a, x.led);           chk("win_time_a", last_e, x.stamp);
            end
         end else if (qa.size() > 0 && qa[0].stamp <= last_e) begin
            fail_evt("valid_a_missing");
            void'(qa.pop_front());
         end
         if (val_b) begin
            if (qb.size() == 0) fail_evt("valid_b_unexpected");
            else begin
               x = qb.pop_front();
               chk("win_res_b", res_b, x.bcd[4*DB-1:0]); chk("win_ovf_b", ovf_b, x.ovf);
               chk("win_led_b", led_b, x.led);           chk("win_time_b", last_e, x.stamp);
            end
         end else if (qb.size() > 0 && qb[0].stamp <= last_e) begin
            fail_evt("valid_b_missing");
            void'(qb.pop_front());
         end
         chk("res_a", res_a, cur_a[4*DA-1:0]); chk("ovf_a", ovf_a, cur_oa); chk("led_a", led_a, led_e);
         chk("res_b", res_b, cur_b[4*DB-1:0]); chk("ovf_b", ovf_b, cur_ob); chk("led_b", led_b, led_e);
         chk_disp("a", DA, seg_a, {6'h3F, sb_a}, disp_a, disp_oa);
         chk_disp("b", DB, seg_b, {8'hFF, sb_b}, disp_b, disp_ob);
      end
   end

   // p >= 2: square wave of period p clk; p == 0: random level every cycle
   task automatic drive(input int cycles, input int p);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (p == 0) input_clk = 1'($urandom_range(0, 1));
         else        input_clk = ((c % p) < (p / 2));
      end
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      // 1 s gate at period 10, switched to 0.1 s 300 cycles into the second window
      drive(1300, 10);
      gate_sel = 1'b1;
      drive(1000, 10);
      // fastest input with 1 s gate: the 2-digit meter saturates
      gate_sel = 1'b0;
      drive(1500, 2);
      // reset partway through a window
      drive(200 + int'($urandom_range(0, 300)), 4);
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      drive(1100, 6);
      for (int ph = 0; ph < 6; ph++) begin
         gate_sel = 1'($urandom_range(0, 1));
         drive(int'($urandom_range(200, 900)),
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 20)));
      end
      drive(1200, 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
